// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational 32-bit ALU between two requesters, for
// example the core datapath (requester 0) and a debug/test unit (requester 1).
// ALU control codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
// Codes are passed through unmodified. Undefined codes are not trapped.
//
// Operation is a three-state sequence with one operation in flight:
//   IDLE : arbitrate and accept one request, latch its operands into op regs
//   EXEC : op regs drive the ALU; capture the ALU result and zero flag
//   RESP : present the response to the owning requester until it accepts
// A request handshake in cycle N gives rsp_valid high from cycle N+2.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                          undefined -> round-robin (default build)
//
// Ports:
//   clk           in   1       single clock, rising edge
//   reset         in   1       synchronous, active-high
//   req_valid     in   2       request valid, bit i = requester i
//   req_ready     out  2       request accept (combinational, IDLE only)
//   req_a0/1      in   WIDTH   operand A of requester 0/1
//   req_b0/1      in   WIDTH   operand B of requester 0/1
//   req_ctrl0/1   in   CTRL_W  ALU control of requester 0/1
//   rsp_valid     out  2       response valid, one-hot to the owner
//   rsp_ready     in   2       response accept, only the owner's bit counts
//   rsp_result    out  WIDTH   registered ALU result
//   rsp_zero      out  1       registered ALU zero flag
//   alu_a/alu_b   out  WIDTH   ALU operands, straight from the op regs
//   alu_ctrl      out  CTRL_W  ALU control, straight from the op regs
//   alu_result    in   WIDTH   ALU result
//   alu_zero      in   1       ALU zero flag
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [WIDTH-1:0]  req_b0,
    input  logic [CTRL_W-1:0] req_ctrl0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [WIDTH-1:0]  req_b1,
    input  logic [CTRL_W-1:0] req_ctrl1,

    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state;
    logic                owner;       // requester that owns the operation in flight
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                last;        // requester served most recently
`endif
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [CTRL_W-1:0]   op_ctrl;
    logic [1:0]          rsp_valid_q;

    logic                grant;       // requester selected this cycle
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic [CTRL_W-1:0]   sel_ctrl;

    // -------------------------------------------------------------------------
    // Arbitration. A lone valid requester is always chosen; on contention the
    // round-robin build picks the requester not served last.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant     = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   grant = 1'b0;
`else
            2'b11:   grant = ~last;
`endif
            default: grant = 1'b0;
        endcase
        if (state == S_IDLE && req_valid != 2'b00) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    assign sel_a    = grant ? req_a1    : req_a0;
    assign sel_b    = grant ? req_b1    : req_b0;
    assign sel_ctrl = grant ? req_ctrl1 : req_ctrl0;

    // The ALU only ever sees registered operands, so its inputs stay quiet
    // outside EXEC and do not ripple with requester activity.
    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_ctrl  = op_ctrl;
    assign rsp_valid = rsp_valid_q;

    // -------------------------------------------------------------------------
    // Control FSM and all datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the operand and result registers are cleared on reset too,
            // so a discarded operation leaves no stale data on the outputs.
            state       <= S_IDLE;
            owner       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last        <= 1'b1;      // requester 0 wins the first contention
`endif
            op_a        <= '0;
            op_b        <= '0;
            op_ctrl     <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_ready != 2'b00) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_ctrl <= sel_ctrl;
                        owner   <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last    <= grant;
`endif
                        state   <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    rsp_result  <= alu_result;
                    rsp_zero    <= alu_zero;
                    rsp_valid_q <= owner ? 2'b10 : 2'b01;
                    state       <= S_RESP;
                end

                S_RESP: begin
                    // Only the owner's ready bit can complete the response.
                    if ((rsp_valid_q & rsp_ready) != 2'b00) begin
                        rsp_valid_q <= 2'b00;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    rsp_valid_q <= 2'b00;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed scenarios (single op, sub to zero, backpressure with wrong-owner
// ready, contention order, reset during EXEC) followed by a randomized phase.
// A request monitor predicts grants and pushes expected responses into a
// queue; a response monitor pops and compares when the owner accepts.
// The external ALU is modelled here as a plain function.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [W-1:0]  ra [2];
    logic [W-1:0]  rb [2];
    logic [2:0]    rc [2];
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_ctrl;
    logic [W-1:0]  alu_result;
    logic          alu_zero;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (ra[0]),
        .req_b0     (rb[0]),
        .req_ctrl0  (rc[0]),
        .req_a1     (ra[1]),
        .req_b1     (rb[1]),
        .req_ctrl1  (rc[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // Behavioural ALU: the arithmetic meaning of each control code.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return ~(a | b);
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        bit           owner;
        logic [W-1:0] res;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   model_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Request monitor: predicts who should be granted and records the answer
    // that requester is owed.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        exp_t       e;
        if (mon_en) begin
            exp_rdy = 2'b00;
            if (sb.size() == 0) begin
                case (req_valid)
                    2'b01: exp_rdy = 2'b01;
                    2'b10: exp_rdy = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                    2'b11: exp_rdy = 2'b01;
`else
                    2'b11: exp_rdy = model_last ? 2'b01 : 2'b10;
`endif
                    default: exp_rdy = 2'b00;
                endcase
            end
            check("req_ready", req_ready, exp_rdy);
            if (exp_rdy != 2'b00) begin
                e.owner = exp_rdy[1];
                e.res   = alu_fn(ra[e.owner], rb[e.owner], rc[e.owner]);
                e.zero  = (e.res == '0);
                e.cyc   = cyc;
                sb.push_back(e);
                model_last = e.owner;
            end
        end
    end

    // Response monitor: compares whatever the DUT presents against the oldest
    // outstanding expectation and retires it on the owner's handshake.
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] own;
        #2;
        if (mon_en) begin
            if (sb.size() == 0) begin
                check("rsp_valid_idle", rsp_valid, 2'b00);
            end else begin
                e   = sb[0];
                own = e.owner ? 2'b10 : 2'b01;
                if (cyc < e.cyc + 2) begin
                    check("rsp_latency", rsp_valid, 2'b00);
                end else begin
                    check("rsp_valid", rsp_valid, own);
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_zero", rsp_zero, e.zero);
                    if ((rsp_ready & own) != 2'b00) void'(sb.pop_front());
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed single operation with optional backpressure. During the stall
    // the other requester's rsp_ready is high and both requests are pending.
    // -------------------------------------------------------------------------
    task automatic single_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] c, input logic [W-1:0] er, input logic ez,
                             input int stall);
        logic [1:0] own;
        own       = (r == 1) ? 2'b10 : 2'b01;
        ra[r]     = a;
        rb[r]     = b;
        rc[r]     = c;
        req_valid = own;
        rsp_ready = (stall > 0) ? ~own : own;
        #1;
        check("idle_req_ready", req_ready, own);
        tick();                                   // handshake edge (cycle N)
        req_valid = 2'b00;
        #1;
        check("exec_rsp_valid", rsp_valid, 2'b00);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_ctrl", alu_ctrl, c);
        tick();                                   // cycle N+2
        check("resp_valid", rsp_valid, own);
        check("resp_result", rsp_result, er);
        check("resp_zero", rsp_zero, ez);
        if (stall > 0) begin
            req_valid = 2'b11;
            for (int s = 0; s < stall; s++) begin
                #1;
                check("bp_req_ready", req_ready, 2'b00);
                check("bp_rsp_valid", rsp_valid, own);
                check("bp_rsp_result", rsp_result, er);
                tick();
            end
            req_valid = 2'b00;
        end
        rsp_ready = own;
        tick();                                   // response handshake
        check("done_rsp_valid", rsp_valid, 2'b00);
        rsp_ready = 2'b00;
    endtask

    task automatic random_phase(input int ncyc);
        logic [1:0] hs;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[i] = 1'b1;
                        ra[i] = $urandom;
                        rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
                        rc[i] = 3'($urandom_range(0, 7));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 1000000);
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [1:0] exp_grant [4];
        int         got;

        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            rc[i] = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_zero", rsp_zero, 1'b0);
        check("rst_alu_a", alu_a, 0);
        check("rst_req_ready_none", req_ready, 2'b00);

        single_op(0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 0);
        single_op(1, 32'h1234, 32'h1234, 3'b001, 32'd0, 1'b1, 0);
        single_op(0, 32'hF0, 32'h0F, 3'b011, 32'hFF, 1'b0, 5);
        single_op(1, 32'hFFFF_FFFD, 32'd2, 3'b101, 32'd1, 1'b0, 0);
        single_op(0, 32'hF0F0, 32'hF0F0, 3'b100, 32'd0, 1'b1, 2);
        single_op(1, 32'hFF00, 32'h0FF0, 3'b010, 32'h0F00, 1'b0, 0);
        single_op(0, 32'd1, 32'd2, 3'b110, 32'hFFFF_FFFC, 1'b0, 0);

        // Contention from reset: both requesters held valid for four ops.
        reset = 1'b1;
        tick();
        reset = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        ra[0] = 32'd10; rb[0] = 32'd3; rc[0] = 3'b000;
        ra[1] = 32'd10; rb[1] = 32'd3; rc[1] = 3'b001;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            #1;
            if (req_ready != 2'b00) begin
                check("contention_grant", req_ready, exp_grant[got]);
                got++;
            end
            tick();
        end
        check("contention_count", got, 4);
        req_valid = 2'b00;
        repeat (4) tick();
        rsp_ready = 2'b00;

        // Reset during EXEC: requester 0 is in flight, so without reset the
        // round-robin would favour requester 1 next.
        ra[0] = 32'd9; rb[0] = 32'd1; rc[0] = 3'b000;
        req_valid = 2'b01;
        #1;
        check("rexec_accept", req_ready, 2'b01);
        tick();                                   // accepted, now in EXEC
        req_valid = 2'b00;
        reset = 1'b1;
        tick();                                   // reset edge during EXEC
        reset = 1'b0;
        check("rexec_rsp_valid", rsp_valid, 2'b00);
        check("rexec_rsp_result", rsp_result, 0);
        check("rexec_rsp_zero", rsp_zero, 1'b0);
        rsp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rexec_no_pulse", rsp_valid, 2'b00);
        end
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        check("rexec_next_contention", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();

        // Randomized traffic against the scoreboard.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_last = 1'b1;
        sb.delete();
        mon_en = 1'b1;
        random_phase(1500);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        tick();
        check("drain_empty", sb.size(), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
